// File: rtl/stallable_pipeline_n.sv
// N-stage stallable pipeline with per-stage valid/allowin; STAGES-cycle latency, 1 item/cycle.
// Backpressure: out_allow ripples back through bubbles; a full pipe with out_allow=0 freezes and drops in_allow.
module stallable_pipeline_n #(
   parameter int WIDTH    = 8,
   parameter int STAGES   = 4,
   parameter int ADD_MODE = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        validin,
   input  logic [WIDTH-1:0]            datain,
   output logic                        in_allow,
   input  logic                        out_allow,
   output logic                        validout,
   output logic [WIDTH-1:0]            dataout,
   output logic [$clog2(STAGES+1)-1:0] occupancy
);

   localparam int OCC_W = $clog2(STAGES+1);
   localparam logic [WIDTH-1:0] INC = WIDTH'(ADD_MODE);

   logic [STAGES-1:0]            valid;
   logic [STAGES-1:0][WIDTH-1:0] data;
   logic [STAGES-1:0]            allowin;
   logic [STAGES-1:0]            pvalid;
   logic [STAGES-1:0][WIDTH-1:0] pdata;
   logic                         allow_acc;
   logic [OCC_W-1:0]             occ_sum;

   // allowin chain walks from the output back; a bubble anywhere downstream lets a stage advance
   always_comb begin
      allowin   = '0;
      allow_acc = !valid[STAGES-1] | out_allow;
      allowin[STAGES-1] = allow_acc;
      for (int i = STAGES-2; i >= 0; i--) begin
         allow_acc  = !valid[i] | allow_acc;
         allowin[i] = allow_acc;
      end
   end

   always_comb begin
      pvalid    = '0;
      pdata     = '0;
      pvalid[0] = validin;
      pdata[0]  = datain;
      for (int i = 1; i < STAGES; i++) begin
         pvalid[i] = valid[i-1];
         pdata[i]  = data[i-1];
      end
   end

   assign in_allow = rst & !flush & allowin[0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
         data  <= '0;
      end else if (flush) begin
         valid <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            if (allowin[i]) begin
               valid[i] <= pvalid[i];
               // bubbles leave the held data untouched
               if (pvalid[i]) data[i] <= pdata[i] + INC;
            end
         end
      end
   end

   always_comb begin
      occ_sum = '0;
      for (int i = 0; i < STAGES; i++) occ_sum = occ_sum + OCC_W'(valid[i]);
   end

   assign occupancy = occ_sum;
   assign validout  = valid[STAGES-1];
   assign dataout   = data[STAGES-1];

endmodule

// File: tb/tb_stallable_pipeline_n.sv
// Directed bench for stallable_pipeline_n (WIDTH=8, STAGES=3), with a pass-through twin for ADD_MODE=0.
module tb_stallable_pipeline_n;

   logic       clk = 1'b0;
   logic       rst, flush, validin, out_allow;
   logic [7:0] datain;
   logic       in_allow, validout;
   logic [7:0] dataout;
   logic [1:0] occupancy;
   logic       in_allow0, validout0;
   logic [7:0] dataout0;
   logic [1:0] occupancy0;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   stallable_pipeline_n #(.WIDTH(8), .STAGES(3), .ADD_MODE(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .validin(validin), .datain(datain),
      .in_allow(in_allow), .out_allow(out_allow), .validout(validout),
      .dataout(dataout), .occupancy(occupancy)
   );

   stallable_pipeline_n #(.WIDTH(8), .STAGES(3), .ADD_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush), .validin(validin), .datain(datain),
      .in_allow(in_allow0), .out_allow(out_allow), .validout(validout0),
      .dataout(dataout0), .occupancy(occupancy0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      logic [7:0] got[$];
      int         idx;
      int         vcount;
      logic       acc;

      rst = 1'b0; flush = 1'b0; validin = 1'b0; datain = 8'h00; out_allow = 1'b0;

      // 1. reset state, then release
      #3;
      check("rst_validout", validout, 0);
      check("rst_dataout", dataout, 8'h00);
      check("rst_occupancy", occupancy, 0);
      check("rst_in_allow", in_allow, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("release_in_allow", in_allow, 1);

      // 2. back-to-back stream
      @(negedge clk);
      out_allow = 1'b1; validin = 1'b1; datain = 8'h10;
      @(negedge clk); datain = 8'h20;
      @(negedge clk); datain = 8'h30;
      @(negedge clk);
      check("stream_occ_full", occupancy, 3);
      check("stream_v0", validout, 1);
      check("stream_d0", dataout, 8'h13);
      validin = 1'b0;
      @(negedge clk);
      check("stream_v1", validout, 1);
      check("stream_d1", dataout, 8'h23);
      @(negedge clk);
      check("stream_v2", validout, 1);
      check("stream_d2", dataout, 8'h33);
      @(negedge clk);
      check("stream_drained_v", validout, 0);
      check("stream_drained_occ", occupancy, 0);

      // 3. backpressure: 5 items offered with consumer stalled
      out_allow = 1'b0;
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         validin = 1'b1; datain = 8'h40 + 8'(idx);
         #1;
         acc = in_allow;
         @(negedge clk);
         if (acc) idx++;
      end
      check("bp_accepted", idx, 3);
      check("bp_occupancy", occupancy, 3);
      check("bp_in_allow", in_allow, 0);
      check("bp_validout", validout, 1);
      check("bp_dataout_held", dataout, 8'h43);
      out_allow = 1'b1;
      for (int c = 0; c < 15; c++) begin
         if (idx < 5) begin validin = 1'b1; datain = 8'h40 + 8'(idx); end
         else validin = 1'b0;
         #1;
         acc = validin && in_allow;
         if (validout && out_allow) got.push_back(dataout);
         @(negedge clk);
         if (acc) idx++;
      end
      validin = 1'b0;
      check("bp_out_count", got.size(), 5);
      for (int k = 0; k < got.size(); k++) check("bp_out_order", got[k], 8'h43 + 8'(k));
      check("bp_drained_occ", occupancy, 0);

      // 4. wrap-around and pass-through twin
      validin = 1'b1; datain = 8'hFE;
      @(negedge clk); datain = 8'hA5;
      @(negedge clk); validin = 1'b0;
      @(negedge clk);
      check("wrap_v", validout, 1);
      check("wrap_d", dataout, 8'h01);
      check("pass_fe", dataout0, 8'hFE);
      @(negedge clk);
      check("add_a5", dataout, 8'hA8);
      check("pass_v", validout0, 1);
      check("pass_a5", dataout0, 8'hA5);
      repeat (3) @(negedge clk);

      // 5. flush with two items in flight and a concurrent offer
      validin = 1'b1; datain = 8'h50;
      @(negedge clk); datain = 8'h51;
      @(negedge clk);
      check("pre_flush_occ", occupancy, 2);
      flush = 1'b1; datain = 8'h52;
      #1;
      check("flush_in_allow", in_allow, 0);
      @(negedge clk);
      flush = 1'b0; validin = 1'b0;
      check("flush_occ", occupancy, 0);
      check("flush_validout", validout, 0);
      check("flush_data_kept", dataout, 8'hA8);
      vcount = 0;
      for (int c = 0; c < 6; c++) begin
         if (validout) vcount++;
         @(negedge clk);
      end
      check("flush_no_ghost", vcount, 0);

      // 6. async reset pulse on a full pipe
      out_allow = 1'b0; validin = 1'b1;
      for (int c = 0; c < 3; c++) begin
         datain = 8'h60 + 8'(c);
         @(negedge clk);
      end
      validin = 1'b0;
      check("full_occ", occupancy, 3);
      check("full_validout", validout, 1);
      #1 rst = 1'b0;
      #1;
      check("arst_validout", validout, 0);
      check("arst_occ", occupancy, 0);
      check("arst_dataout", dataout, 8'h00);
      check("arst_in_allow", in_allow, 0);
      #1 rst = 1'b1;
      @(negedge clk);
      check("restart_in_allow", in_allow, 1);
      out_allow = 1'b1; validin = 1'b1; datain = 8'h70;
      @(negedge clk); validin = 1'b0;
      @(negedge clk);
      check("restart_not_early", validout, 0);
      @(negedge clk);
      check("restart_v", validout, 1);
      check("restart_d", dataout, 8'h73);
      @(negedge clk);
      check("restart_end_occ", occupancy, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
